wb_host_master: RTL and testbench

Wishbone classic single-transfer initiator that drives the user-project Wishbone slave port (`wbs_*` of the user macros) from a simple command/response stream. It sits on the host side of the wrapper, in the test harness and in the management-side bring-up logic. It converts one command into one Wishbone cycle, waits for `ack` or a timeout, then returns read data and an error flag. One transaction is outstanding at a time, and timeouts are counted.

---
 rtl/wb_host_master.sv | 113 +++++++++++
 tb/tb_wb_host_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out, with a per-transfer timeout and a saturating timeout counter.
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_adr_i,
    input  logic [31:0]          cmd_dat_i,
    input  logic [3:0]           cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [31:0]          wbm_dat_i,
    output logic                 busy_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    // Counter only has to reach TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES) bits suffice.
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TO_LASTI = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LASTI);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    assign cmd_ready_o = (state == IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            to_cnt      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            busy_o      <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        wbm_sel_o <= cmd_sel_i;
                        to_cnt    <= '0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (TO_EN && (to_cnt == TO_LAST)) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        if (err_cnt_o != '1) begin
                            err_cnt_o <= err_cnt_o + 1'b1;
                        end
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master (TIMEOUT_CYCLES=4, ERR_CNT_W=8).
module tb_wb_host_master;

    logic        wb_clk_i;
    logic        wb_rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy_o;
    logic [7:0]  err_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wb_host_master #(
        .TIMEOUT_CYCLES(4),
        .ERR_CNT_W     (8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .cmd_sel_i  (cmd_sel_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i),
        .busy_o     (busy_o),
        .err_cnt_o  (err_cnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Present a command in IDLE; it is accepted on the next edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        check("cmd_ready_before_issue", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        tick();
        cmd_valid_i = 1'b0;
        cmd_adr_i   = 32'hFFFF_FFFF;
        cmd_dat_i   = 32'hFFFF_FFFF;
    endtask

    task automatic silent_timeout();
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
        repeat (4) tick();
        tick();
    endtask

    initial begin
        wb_rst_ni   = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_dat_i   = '0;

        #1 wb_rst_ni = 1'b0;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_dat",   rsp_dat_o,        32'd0);
        check("rst_rsp_err",   32'(rsp_err_o),   32'd0);
        check("rst_cyc",       32'(wbm_cyc_o),   32'd0);
        check("rst_stb",       32'(wbm_stb_o),   32'd0);
        check("rst_we",        32'(wbm_we_o),    32'd0);
        check("rst_sel",       32'(wbm_sel_o),   32'd0);
        check("rst_adr",       wbm_adr_o,        32'd0);
        check("rst_dat",       wbm_dat_o,        32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_err_cnt",   32'(err_cnt_o),   32'd0);
        tick();
        tick();
        wb_rst_ni = 1'b1;
        tick();

        // Write, ack in the 2nd stb cycle; slave drives junk read data that must be ignored.
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        check("wr_stb1",       32'(wbm_stb_o),   32'd1);
        check("wr_cyc1",       32'(wbm_cyc_o),   32'd1);
        check("wr_we",         32'(wbm_we_o),    32'd1);
        check("wr_adr",        wbm_adr_o,        32'h3000_0004);
        check("wr_dat",        wbm_dat_o,        32'hA5A5_1234);
        check("wr_sel",        32'(wbm_sel_o),   32'hF);
        check("wr_busy",       32'(busy_o),      32'd1);
        check("wr_cmd_ready",  32'(cmd_ready_o), 32'd0);
        tick();
        check("wr_stb2",       32'(wbm_stb_o),   32'd1);
        check("wr_adr2",       wbm_adr_o,        32'h3000_0004);
        check("wr_rsp_valid0", 32'(rsp_valid_o), 32'd0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1111_2222;
        tick();
        wbm_ack_i = 1'b0;
        check("wr_stb_end",    32'(wbm_stb_o),   32'd0);
        check("wr_cyc_end",    32'(wbm_cyc_o),   32'd0);
        check("wr_rsp_valid",  32'(rsp_valid_o), 32'd1);
        check("wr_rsp_err",    32'(rsp_err_o),   32'd0);
        check("wr_rsp_dat",    rsp_dat_o,        32'd0);
        check("wr_adr_held",   wbm_adr_o,        32'h3000_0004);
        rsp_ready_i = 1'b1;
        tick();
        check("wr_rsp_done",   32'(rsp_valid_o), 32'd0);
        check("wr_idle",       32'(cmd_ready_o), 32'd1);
        check("wr_busy_done",  32'(busy_o),      32'd0);

        // Read with zero-wait ack; ack raised already in IDLE is ignored there.
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        check("idle_stray_ack", 32'(rsp_valid_o), 32'd0);
        check("idle_stray_cyc", 32'(wbm_cyc_o),   32'd0);
        issue(1'b0, 32'h3000_0000, 32'h0, 4'h3);
        check("rd_stb",        32'(wbm_stb_o),   32'd1);
        check("rd_we",         32'(wbm_we_o),    32'd0);
        check("rd_adr",        wbm_adr_o,        32'h3000_0000);
        check("rd_sel",        32'(wbm_sel_o),   32'h3);
        check("rd_rsp_early",  32'(rsp_valid_o), 32'd0);
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("rd_rsp_valid",  32'(rsp_valid_o), 32'd1);
        check("rd_rsp_dat",    rsp_dat_o,        32'hDEAD_BEEF);
        check("rd_cyc_end",    32'(wbm_cyc_o),   32'd0);
        tick();
        check("rd_idle",       32'(cmd_ready_o), 32'd1);

        // Timeout: stb high for exactly 4 cycles, then error response.
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        check("to_stb1", 32'(wbm_stb_o), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("to_stb%0d", i), 32'(wbm_stb_o), 32'd1);
        end
        rsp_ready_i = 1'b0;
        tick();
        check("to_stb_end",    32'(wbm_stb_o),   32'd0);
        check("to_rsp_valid",  32'(rsp_valid_o), 32'd1);
        check("to_rsp_err",    32'(rsp_err_o),   32'd1);
        check("to_rsp_dat",    rsp_dat_o,        32'd0);
        check("to_err_cnt",    32'(err_cnt_o),   32'd1);
        rsp_ready_i = 1'b1;
        tick();
        check("to_idle",       32'(cmd_ready_o), 32'd1);

        // Ack in the 4th stb cycle wins over the timeout.
        rsp_ready_i = 1'b0;
        issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        repeat (3) tick();
        check("ta_stb4", 32'(wbm_stb_o), 32'd1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_0055;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("ta_rsp_valid",  32'(rsp_valid_o), 32'd1);
        check("ta_rsp_err",    32'(rsp_err_o),   32'd0);
        check("ta_rsp_dat",    rsp_dat_o,        32'h0000_0055);
        check("ta_err_cnt",    32'(err_cnt_o),   32'd1);

        // Backpressure for 5 cycles with a stray ack and a pending command.
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wbm_ack_i = (i == 2);
            wbm_dat_i = 32'h7777_7777;
            tick();
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_rsp_dat",   rsp_dat_o,        32'h0000_0055);
            check("bp_rsp_err",   32'(rsp_err_o),   32'd0);
            check("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("bp_cyc",       32'(wbm_cyc_o),   32'd0);
        end
        cmd_valid_i = 1'b0;
        wbm_ack_i   = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        check("bp_rsp_done",   32'(rsp_valid_o), 32'd0);
        check("bp_idle",       32'(cmd_ready_o), 32'd1);
        check("bp_dat_kept",   rsp_dat_o,        32'h0000_0055);
        check("bp_err_cnt",    32'(err_cnt_o),   32'd1);

        // 300 more timeouts saturate the 8-bit counter.
        for (int i = 0; i < 300; i++) silent_timeout();
        check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        check("sat_idle",    32'(cmd_ready_o), 32'd1);

        // Asynchronous reset in the middle of a bus cycle.
        issue(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'hC);
        check("mr_stb", 32'(wbm_stb_o), 32'd1);
        #2 wb_rst_ni = 1'b0;
        #1;
        check("mr_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("mr_cyc",       32'(wbm_cyc_o),   32'd0);
        check("mr_stb_low",   32'(wbm_stb_o),   32'd0);
        check("mr_we",        32'(wbm_we_o),    32'd0);
        check("mr_adr",       wbm_adr_o,        32'd0);
        check("mr_dat",       wbm_dat_o,        32'd0);
        check("mr_sel",       32'(wbm_sel_o),   32'd0);
        check("mr_busy",      32'(busy_o),      32'd0);
        check("mr_err_cnt",   32'(err_cnt_o),   32'd0);
        check("mr_rsp_err",   32'(rsp_err_o),   32'd0);
        check("mr_rsp_valid", 32'(rsp_valid_o), 32'd0);
        tick();
        tick();
        wb_rst_ni = 1'b1;
        tick();
        check("mr_post_ready", 32'(cmd_ready_o), 32'd1);
        check("mr_post_rsp",   32'(rsp_valid_o), 32'd0);
        issue(1'b0, 32'h3000_0014, 32'h0, 4'h1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        check("mr_rd_valid", 32'(rsp_valid_o), 32'd1);
        check("mr_rd_dat",   rsp_dat_o,        32'h1234_5678);
        check("mr_rd_err",   32'(rsp_err_o),   32'd0);
        tick();
        check("mr_rd_idle",  32'(cmd_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
